channel_peak_packer: RTL and testbench
======================================

Name: channel_peak_packer

Overview:
- Upstream neighbour of the OSC/UDP framer.
- Consumes an interleaved stream of signed 16-bit samples from four drum pickup channels, tagged ch0..ch3.
- Tracks the per-channel peak magnitude over a window of WINDOW sample groups.
- At each window close, emits one 64-bit word {pk3,pk2,pk1,pk0} on an AXI-Stream master that feeds the framer's s_axis port.
- Never backpressures the sample source; a slow framer causes latest-wins replacement.

Parameters:
- WINDOW, 1024, sample groups (ch0..ch3 sets) per window; legal range 2..65535.
- CNT_W, 16, width of the window counter; must hold WINDOW-1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  16  signed two's-complement sample
- s_axis_tuser  in  2  channel id of the sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  always ready once out of reset
- m_axis_tdata  out  64  packed peaks: pk0 in [15:0], pk1 in [31:16], pk2 in [47:32], pk3 in [63:48]
- m_axis_tvalid  out  1  packed word valid
- m_axis_tready  in  1  framer ready
- seq_err  out  1  one-cycle pulse on a channel-order violation
- drop_cnt  out  16  windows overwritten before the framer accepted them

Behaviour:
- Reset: one clock (aclk); asynchronous active-low reset (aresetn).
- Reset values: all outputs 0, state ALIGN, peaks 0, window counter 0, expected channel 0.
- s_axis_tready is a register set to 1 on the first clock after aresetn deasserts.
- Beat: accepted when s_axis_tvalid && s_axis_tready.
- Magnitude: abs = |sample|, saturated so that -32768 gives 32767. The result is unsigned 15-bit, zero-extended to 16 bits.
- State ALIGN: accepted beats are discarded. A beat with tuser==3 moves the block to ACCUM with expected channel 0, counter 0 and peaks 0.
- State ACCUM:
  - If tuser == expected channel: peak[ch] <= max(peak[ch], abs), and the expected channel increments mod 4.
  - If tuser != expected channel: pulse seq_err for one cycle the next cycle, discard the beat, clear the peaks and counter, and go to ALIGN. No word is emitted.
  - An accepted ch3 beat closes a group. If the counter < WINDOW-1, the counter increments.
  - If the counter == WINDOW-1, the window closes: the peaks, including the closing ch3 sample, load into m_axis_tdata. m_axis_tvalid = 1 on the next cycle, then the counter and all peaks clear to 0.
- Output handshake:
  - tdata is stable while tvalid && !tready.
  - tvalid drops the cycle after a transfer unless a new window closed in the same cycle.
  - Close while tvalid && !tready: tdata is replaced by the new word, tvalid stays 1, and drop_cnt increments (saturating at 0xFFFF).
  - Close in the same cycle as a transfer (tvalid && tready): the old word transfers, the new word loads, tvalid stays 1, and there is no drop.
- Latency: window close beat to m_axis_tvalid is 1 cycle.
- Reset mid-window or mid-hold: everything is lost immediately (asynchronous); the block restarts in ALIGN.
- Idle gaps in s_axis_tvalid hold all state.

Optional Feature:
- Macro: CHANNEL_PEAK_PACKER_DROP_CNT_EN.
- Defined: the saturating 16-bit drop counter is built and drives drop_cnt. It clears only on reset.
- Undefined: there is no counter logic and drop_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package/header contents:
  - NUM_CH=4 and SAMPLE_W=16.
  - State encodings ALIGN=1'b0 and ACCUM=1'b1.
  - Lane offset constants for packing (LANE_W=16).
  - The same lane order is consumed by the framer.
- One natural sub-module: abs_sat16. It is combinational, takes a signed 16-bit input and gives a saturated 16-bit magnitude, and is instanced once ahead of the peak compare.

Test Plan:
- Alignment (WINDOW=2): send ch2,ch3, then groups of ch0..ch3 with values 100,-200,300,-400 and then 50,50,50,50 → beats before the first ch3 are ignored. One word 0x0190_012C_00C8_0064 appears 1 cycle after the second group's ch3, and m_axis_tvalid holds until tready.
- Saturation (WINDOW=2): ch0=-32768 in group 1, everything else 0 → pk0=0x7FFF and all other lanes 0.
- Order error: in ACCUM send ch0,ch2 → seq_err is a single-cycle pulse, no word is emitted, and a later ch3 plus full groups produce correct peaks starting from 0.
- Backpressure (WINDOW=2, m_axis_tready=0): close three windows → tdata equals the third window's peaks, and drop_cnt=2 with the macro defined (0 with it undefined).
- Simultaneous (WINDOW=2): assert tready in exactly the cycle the second window closes → the first word transfers, the second word is valid the next cycle, and drop_cnt is unchanged.
- Reset mid-window: pulse aresetn low asynchronously between clock edges in ACCUM → all outputs are 0 immediately, tready returns 1 the cycle after release, and the next output needs a fresh ch3 alignment.

Source files
------------

// File: rtl/channel_peak_packer_pkg.sv
// Shared constants and types for channel_peak_packer: channel count, lane layout, FSM states.
// The lane order {pk3,pk2,pk1,pk0} is the same order the downstream framer unpacks.
package channel_peak_packer_pkg;

   localparam int unsigned NUM_CH   = 4;
   localparam int unsigned CH_W     = 2;
   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned LANE_W   = 16;
   localparam int unsigned OUT_W    = NUM_CH * LANE_W;

   typedef enum logic {
      ALIGN = 1'b0,
      ACCUM = 1'b1
   } state_e;

   // Packed so that lane i occupies bits [i*LANE_W +: LANE_W] of the output word.
   typedef logic [NUM_CH-1:0][LANE_W-1:0] peaks_t;

   function automatic int unsigned lane_lo(input int unsigned lane);
      return lane * LANE_W;
   endfunction

endpackage

// File: rtl/channel_peak_packer_if.sv
// AXI-Stream style bundle used for both the sample input and the packed-peak output.
interface channel_peak_packer_if
   import channel_peak_packer_pkg::*;
#(
   parameter int unsigned DATA_W = SAMPLE_W,
   parameter int unsigned USER_W = CH_W
) ();

   logic [DATA_W-1:0] tdata;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tready;

   modport master (
      output tdata,
      output tuser,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tuser,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/channel_peak_packer_abs_sat16.sv
// Combinational saturated magnitude of a signed sample; -32768 maps to 32767.
module abs_sat16
   import channel_peak_packer_pkg::*;
(
   input  logic [SAMPLE_W-1:0] din,
   output logic [SAMPLE_W-1:0] mag
);

   localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] ONE      = {{(SAMPLE_W-1){1'b0}}, 1'b1};

   always_comb begin
      mag = din;
      if (din == MOST_NEG) begin
         mag = MOST_POS;
      end else if (din[SAMPLE_W-1]) begin
         mag = ~din + ONE;
      end
   end

endmodule

// File: rtl/channel_peak_packer.sv
// Per-channel peak tracker over WINDOW ch0..ch3 groups; emits {pk3,pk2,pk1,pk0} per window.
// Optional saturating overwrite counter on drop_cnt when CHANNEL_PEAK_PACKER_DROP_CNT_EN is defined.
module channel_peak_packer
   import channel_peak_packer_pkg::*;
#(
   parameter int unsigned WINDOW = 1024,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   channel_peak_packer_if.slave  s_axis,
   channel_peak_packer_if.master m_axis,
   output logic                  seq_err,
   output logic [LANE_W-1:0]     drop_cnt
);

   localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(WINDOW - 1);
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

   state_e             state_q, state_d;
   logic               s_tready_q, s_tready_d;
   logic [CH_W-1:0]    exp_ch_q, exp_ch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   peaks_t             peak_q, peak_d;
   peaks_t             peaks_upd;
   logic               seq_err_q, seq_err_d;
   logic [OUT_W-1:0]   m_tdata_q, m_tdata_d;
   logic               m_tvalid_q, m_tvalid_d;

   logic               beat;
   logic               close;
   logic [CH_W-1:0]    ch;
   logic [SAMPLE_W-1:0] mag;

   abs_sat16 u_abs (
      .din (s_axis.tdata),
      .mag (mag)
   );

   assign beat = s_axis.tvalid && s_tready_q;
   assign ch   = s_axis.tuser;

   // Peaks with the current sample folded in; used both for accumulation and the closing word.
   always_comb begin
      peaks_upd = peak_q;
      if (mag > peak_q[ch]) begin
         peaks_upd[ch] = mag;
      end
   end

   always_comb begin
      state_d    = state_q;
      s_tready_d = 1'b1;
      exp_ch_d   = exp_ch_q;
      cnt_d      = cnt_q;
      peak_d     = peak_q;
      seq_err_d  = 1'b0;
      close      = 1'b0;

      if (beat) begin
         unique case (state_q)
            ALIGN: begin
               if (ch == LAST_CH) begin
                  state_d  = ACCUM;
                  exp_ch_d = '0;
                  cnt_d    = '0;
                  peak_d   = '0;
               end
            end
            ACCUM: begin
               if (ch == exp_ch_q) begin
                  peak_d   = peaks_upd;
                  exp_ch_d = exp_ch_q + CH_W'(1);
                  if (ch == LAST_CH) begin
                     if (cnt_q == LAST_GROUP) begin
                        close  = 1'b1;
                        cnt_d  = '0;
                        peak_d = '0;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
               end else begin
                  seq_err_d = 1'b1;
                  state_d   = ALIGN;
                  exp_ch_d  = '0;
                  cnt_d     = '0;
                  peak_d    = '0;
               end
            end
            default: state_d = ALIGN;
         endcase
      end
   end

   // A close always wins over a transfer: the new word is valid the next cycle either way.
   always_comb begin
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      if (close) begin
         m_tdata_d  = peaks_upd;
         m_tvalid_d = 1'b1;
      end else if (m_tvalid_q && m_axis.tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ALIGN;
         s_tready_q <= 1'b0;
         exp_ch_q   <= '0;
         cnt_q      <= '0;
         peak_q     <= '0;
         seq_err_q  <= 1'b0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_tready_q <= s_tready_d;
         exp_ch_q   <= exp_ch_d;
         cnt_q      <= cnt_d;
         peak_q     <= peak_d;
         seq_err_q  <= seq_err_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
      end
   end

`ifdef CHANNEL_PEAK_PACKER_DROP_CNT_EN
   logic              overwrite;
   logic [LANE_W-1:0] drop_q, drop_d;

   assign overwrite = close && m_tvalid_q && !m_axis.tready;

   always_comb begin
      drop_d = drop_q;
      if (overwrite && (drop_q != '1)) begin
         drop_d = drop_q + LANE_W'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

   assign s_axis.tready = s_tready_q;
   assign m_axis.tdata  = m_tdata_q;
   assign m_axis.tuser  = '0;
   assign m_axis.tvalid = m_tvalid_q;
   assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_channel_peak_packer.sv
// Directed bench for channel_peak_packer (WINDOW=2) with a word scoreboard queue.
module tb_channel_peak_packer;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic        seq_err;
   logic [15:0] drop_cnt;

   channel_peak_packer_if #(.DATA_W(16), .USER_W(2)) s_if ();
   channel_peak_packer_if #(.DATA_W(64), .USER_W(1)) m_if ();

   channel_peak_packer #(
      .WINDOW (2),
      .CNT_W  (16)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_axis   (s_if),
      .m_axis   (m_if),
      .seq_err  (seq_err),
      .drop_cnt (drop_cnt)
   );

   always #5 aclk = ~aclk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // reference model state
   bit          mdl_acc;
   int          mdl_exp;
   int          mdl_cnt;
   int          mdl_pk [4];
   int          mdl_drop;
   logic [63:0] exp_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mdl_clear();
      mdl_acc  = 1'b0;
      mdl_exp  = 0;
      mdl_cnt  = 0;
      foreach (mdl_pk[i]) mdl_pk[i] = 0;
      mdl_drop = 0;
      exp_q.delete();
   endtask

   function automatic logic [63:0] mdl_word();
      return {16'(mdl_pk[3]), 16'(mdl_pk[2]), 16'(mdl_pk[1]), 16'(mdl_pk[0])};
   endfunction

   // One clock; any transfer happening on this edge is checked against the queue head.
   task automatic tick();
      logic        x;
      logic [63:0] d;
      x = m_if.tvalid && m_if.tready;
      d = m_if.tdata;
      @(negedge aclk);
      if (x) begin
         chk("xfer_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) chk("xfer_word", d, exp_q.pop_front());
      end
   endtask

   task automatic beat(input int ch, input int val);
      int          mag;
      bit          err;
      bit          close;
      logic [63:0] w;
      mag   = (val < 0) ? -val : val;
      if (mag > 32767) mag = 32767;
      err   = 1'b0;
      close = 1'b0;
      w     = '0;
      if (!mdl_acc) begin
         if (ch == 3) begin
            mdl_acc = 1'b1;
            mdl_exp = 0;
            mdl_cnt = 0;
            foreach (mdl_pk[i]) mdl_pk[i] = 0;
         end
      end else if (ch != mdl_exp) begin
         err     = 1'b1;
         mdl_acc = 1'b0;
         mdl_cnt = 0;
         foreach (mdl_pk[i]) mdl_pk[i] = 0;
      end else begin
         if (mag > mdl_pk[ch]) mdl_pk[ch] = mag;
         mdl_exp = (mdl_exp + 1) % 4;
         if (ch == 3) begin
            if (mdl_cnt == 1) begin
               close = 1'b1;
               w     = mdl_word();
               mdl_cnt = 0;
               foreach (mdl_pk[i]) mdl_pk[i] = 0;
            end else begin
               mdl_cnt++;
            end
         end
      end
      if (close) begin
         if (exp_q.size() > 0 && !m_if.tready) begin
            exp_q[exp_q.size()-1] = w;
            mdl_drop++;
         end else begin
            exp_q.push_back(w);
         end
      end
      s_if.tvalid = 1'b1;
      s_if.tuser  = 2'(ch);
      s_if.tdata  = 16'(val);
      tick();
      s_if.tvalid = 1'b0;
      chk("seq_err", 64'(seq_err), 64'(err));
      if (close) begin
         chk("close_tvalid", 64'(m_if.tvalid), 64'd1);
         chk("close_tdata", m_if.tdata, w);
      end
   endtask

   task automatic group(input int a, input int b, input int c, input int d);
      beat(0, a);
      beat(1, b);
      beat(2, c);
      beat(3, d);
   endtask

   task automatic pull(input string tag);
      int n;
      n = 0;
      m_if.tready = 1'b1;
      while (!m_if.tvalid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 64'(m_if.tvalid), 64'd1);
      tick();
      m_if.tready = 1'b0;
      chk({tag, "_tvalid_after"}, 64'(m_if.tvalid), 64'(exp_q.size() > 0));
   endtask

   function automatic logic [63:0] exp_drop();
`ifdef CHANNEL_PEAK_PACKER_DROP_CNT_EN
      return 64'(mdl_drop);
`else
      return 64'd0;
`endif
   endfunction

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset(input string tag);
      @(negedge aclk);
      #2 aresetn = 1'b0;
      mdl_clear();
      #1;
      chk({tag, "_s_tready"}, 64'(s_if.tready), 64'd0);
      chk({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
      chk({tag, "_m_tdata"}, m_if.tdata, 64'd0);
      chk({tag, "_seq_err"}, 64'(seq_err), 64'd0);
      chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
      @(negedge aclk);
      #2 aresetn = 1'b1;
      #1;
      chk({tag, "_tready_pre"}, 64'(s_if.tready), 64'd0);
      @(negedge aclk);
      chk({tag, "_tready_post"}, 64'(s_if.tready), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] drop_before;
      s_if.tvalid = 1'b0;
      s_if.tuser  = '0;
      s_if.tdata  = '0;
      m_if.tready = 1'b0;
      mdl_clear();

      do_reset("reset");

      // Alignment: ch2 is ignored, ch3 aligns, window closes on the second group
      beat(2, 100);
      beat(3, 5);
      group(100, -200, 300, -400);
      group(50, 50, 50, 50);
      chk("align_word", m_if.tdata, 64'h0190_012C_00C8_0064);
      repeat (3) tick();
      chk("align_hold_valid", 64'(m_if.tvalid), 64'd1);
      chk("align_hold_data", m_if.tdata, 64'h0190_012C_00C8_0064);
      pull("align");

      // Saturation of the most negative sample
      group(-32768, 0, 0, 0);
      group(0, 0, 0, 0);
      chk("sat_word", m_if.tdata, 64'h0000_0000_0000_7FFF);
      pull("sat");

      // Order error
      beat(0, 1);
      beat(2, 2);
      tick();
      chk("seq_err_single", 64'(seq_err), 64'd0);
      chk("seq_no_word", 64'(m_if.tvalid), 64'd0);
      beat(3, 9);
      group(7, 8, 9, 10);
      group(1, 1, 1, 1);
      chk("realign_word", m_if.tdata, 64'h000A_0009_0008_0007);
      pull("realign");

      // Backpressure: three closes with tready low
      group(1, 2, 3, 4);
      group(0, 0, 0, 0);
      group(5, 6, 7, 8);
      group(0, 0, 0, 0);
      group(11, 12, 13, 14);
      group(0, 0, 0, 0);
      chk("bp_word", m_if.tdata, 64'h000E_000D_000C_000B);
      chk("bp_drop_cnt", 64'(drop_cnt), exp_drop());
      chk("bp_queue", 64'(exp_q.size()), 64'd1);
      pull("bp");

      // Close in the same cycle as a transfer
      drop_before = exp_drop();
      group(21, 22, 23, 24);
      group(0, 0, 0, 0);
      group(31, 32, 33, 34);
      beat(0, 0);
      beat(1, 0);
      beat(2, 0);
      m_if.tready = 1'b1;
      beat(3, 0);
      m_if.tready = 1'b0;
      chk("simul_tvalid", 64'(m_if.tvalid), 64'd1);
      chk("simul_word", m_if.tdata, 64'h0022_0021_0020_001F);
      chk("simul_drop_cnt", 64'(drop_cnt), drop_before);
      pull("simul");

      // Reset while a word is held and a window is in progress
      group(41, 42, 43, 44);
      group(0, 0, 0, 0);
      beat(0, 3);
      beat(1, 4);
      do_reset("midreset");
      group(60, 61, 62, 63);
      chk("midreset_no_word_a", 64'(m_if.tvalid), 64'd0);
      group(1, 2, 3, 4);
      chk("midreset_no_word_b", 64'(m_if.tvalid), 64'd0);
      group(5, 6, 7, 8);
      chk("midreset_word", m_if.tdata, 64'h0008_0007_0006_0005);
      pull("midreset");

      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
